mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Arbitrates the single data-memory port between the pipeline MEM stage (core) and an auxiliary requester (program loader / debug access). The core has priority. A saturating starvation counter guarantees the aux side a slot within a bounded number of cycles. Sits between the MEM stage and the data memory, drives the memory's control/address/data inputs, and returns a stall to the pipeline hazard logic when the core loses a cycle.

## Interface
- ADDR_W, 12, memory byte-address width
- STARVE_LIMIT, 4, aux wait cycles before a forced aux grant (1..2^CNT_W-1)
- CNT_W, 3, starvation counter width
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- core_req  in  1  MEM stage has a load or store this cycle
- core_we  in  1  core store (1) / load (0)
- core_addr  in  ADDR_W  core address
- core_wdata  in  32  core store data
- core_store_type  in  2  core store width code (passed through)
- core_load_type  in  3  core load width/sign code (passed through)
- core_rdata  out  32  combinational memory read data to the core
- core_stall  out  1  core request not served this cycle; pipeline holds MEM stage
- aux_req  in  1  aux request; held stable until aux_gnt
- aux_we, aux_addr, aux_wdata, aux_store_type, aux_load_type  in  1/ADDR_W/32/2/3  as core equivalents
- aux_gnt  out  1  aux request accepted this cycle
- aux_rdata  out  32  registered aux load data
- aux_rvalid  out  1  one-cycle pulse, aux_rdata valid
- mem_write, mem_addr, mem_wdata, mem_store_type, mem_load_type  out  1/ADDR_W/32/2/3  to data memory
- mem_rdata  in  32  combinational read data from data memory

## Operation
- force_aux = (starve_cnt == STARVE_LIMIT).
- aux_gnt = !rst && aux_req && (!core_req || force_aux). core_stall = !rst && core_req && aux_gnt.
- Winner drives the mem_* signals; aux when aux_gnt, otherwise core. mem_write = 0 when there is no winner or rst is high; mem_addr/mem_wdata then follow the core inputs.
- core_rdata = mem_rdata at all times. The core uses it only when !core_stall.
- Starvation counter, updated each clock:
  - 0 on rst, on aux_gnt, or when !aux_req.
  - Otherwise +1, saturating at STARVE_LIMIT.
- Aux read capture: on aux_gnt && !aux_we, aux_rdata <= mem_rdata and aux_rvalid <= 1. Otherwise aux_rvalid <= 0. aux_rdata holds its value.
- Aux writes produce no aux_rvalid.
- After a forced aux slot the counter is 0, so a pending core request wins the next cycle. The core is never stalled two consecutive cycles.
- Aux changing its request fields before aux_gnt is illegal. Behaviour in that case is undefined, with no recovery logic.

## Timing
- Reset values: starve_cnt 0, aux_rdata 0, aux_rvalid 0, aux_gnt 0, core_stall 0, mem_write 0.
- Grant, stall and mem_* muxing are combinational in the same cycle as the request. Memory writes occur at the clock edge ending the grant cycle.
- Aux read latency: aux_rvalid asserts in the cycle after aux_gnt.
- Maximum aux wait with core continuously requesting: STARVE_LIMIT cycles, granted in cycle STARVE_LIMIT+1.
- rst asserted mid-wait clears the counter. Grant is suppressed during rst, and a pending aux_rvalid is cleared on the next edge.
- Simultaneous core_req and aux_req with counter below the limit: core wins, counter increments.

## Configuration
- MEM_PORT_ARBITER_STARVE_EN defined: starvation counter and forced aux grant as described.
- Not defined: no counter, force_aux tied 0. Strict core priority; aux is granted only in cycles with !core_req. core_stall is constant 0.

## Test plan
- Core only: core_req=1, core_we=1, addr 0x010, wdata 0xDEADBEEF, store_type word; then a core load of 0x010 -> mem_write=1 in the first cycle, core_rdata=0xDEADBEEF, core_stall=0 throughout, aux_gnt=0.
- Aux only: aux write 0x020=0x12345678, then aux read 0x020 -> aux_gnt in the same cycle as each request, aux_rvalid pulses one cycle after the read grant, aux_rdata=0x12345678.
- Contention, STARVE_LIMIT=4: core_req held high, aux read pending from cycle 0 -> aux_gnt and core_stall high in cycle 4 only; core wins cycle 5; aux_rvalid high in cycle 5.
- Back-to-back aux with core busy -> forced grants alternate with at least one core cycle; core_stall is never high in two consecutive cycles.
- Reset mid-wait: aux pending 3 cycles, rst for 1 cycle -> counter 0, no grant during rst, forced grant 4 cycles after rst deasserts.
- Macro undefined: core_req held high 10 cycles with aux pending -> aux_gnt=0 and core_stall=0 throughout; aux granted in the first cycle core_req drops.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Data-memory port arbiter: core has priority, aux requester shares the port.
// Optional starvation guard enabled by defining MEM_PORT_ARBITER_STARVE_EN.
module mem_port_arbiter #(
    parameter int ADDR_W       = 12,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [31:0]       core_wdata,
    input  logic [1:0]        core_store_type,
    input  logic [2:0]        core_load_type,
    output logic [31:0]       core_rdata,
    output logic              core_stall,
    input  logic              aux_req,
    input  logic              aux_we,
    input  logic [ADDR_W-1:0] aux_addr,
    input  logic [31:0]       aux_wdata,
    input  logic [1:0]        aux_store_type,
    input  logic [2:0]        aux_load_type,
    output logic              aux_gnt,
    output logic [31:0]       aux_rdata,
    output logic              aux_rvalid,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [1:0]        mem_store_type,
    output logic [2:0]        mem_load_type,
    input  logic [31:0]       mem_rdata
);

    logic        force_aux_s;
    logic        aux_gnt_s;
    logic        core_win_s;
    logic [31:0] aux_rdata_r;
    logic        aux_rvalid_r;

`ifdef MEM_PORT_ARBITER_STARVE_EN
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    logic [CNT_W-1:0] starve_cnt_r;

    // Counts consecutive cycles aux has waited; saturates at the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_r <= '0;
        end else if (aux_gnt_s || !aux_req) begin
            starve_cnt_r <= '0;
        end else if (starve_cnt_r != LIMIT_C) begin
            starve_cnt_r <= starve_cnt_r + ONE_C;
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

    assign force_aux_s = (starve_cnt_r == LIMIT_C);
`else
    assign force_aux_s = 1'b0;
`endif

    // Same-cycle grant decision and port mux; the core owns the port by default.
    always_comb begin
        aux_gnt_s      = !rst && aux_req && (!core_req || force_aux_s);
        core_win_s     = !rst && core_req && !aux_gnt_s;
        core_stall     = !rst && core_req && aux_gnt_s;
        mem_addr       = core_addr;
        mem_wdata      = core_wdata;
        mem_store_type = core_store_type;
        mem_load_type  = core_load_type;
        mem_write      = 1'b0;
        if (aux_gnt_s) begin
            mem_addr       = aux_addr;
            mem_wdata      = aux_wdata;
            mem_store_type = aux_store_type;
            mem_load_type  = aux_load_type;
            mem_write      = aux_we;
        end else if (core_win_s) begin
            mem_write = core_we;
        end else begin
            mem_write = 1'b0;
        end
    end

    // Aux load data is captured at the end of its grant cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            aux_rdata_r  <= 32'h0000_0000;
            aux_rvalid_r <= 1'b0;
        end else if (aux_gnt_s && !aux_we) begin
            aux_rdata_r  <= mem_rdata;
            aux_rvalid_r <= 1'b1;
        end else begin
            aux_rdata_r  <= aux_rdata_r;
            aux_rvalid_r <= 1'b0;
        end
    end

    assign aux_gnt    = aux_gnt_s;
    assign aux_rdata  = aux_rdata_r;
    assign aux_rvalid = aux_rvalid_r;
    assign core_rdata = mem_rdata;

endmodule
